misex2_cmd_encoder: RTL and testbench

- Sequential encoder and transmitter for the misex2 control-word decoder, driving the decoder from its input side.
- Takes asynchronous-to-the-decoder event requests, one per decoder output (18 total), and arbitrates them round-robin.
- Emits, one at a time over a valid/ready handshake, the canonical 25-bit input word that asserts the requested output.
- Inserts a programmable dwell gap after each transfer so the downstream combinational/FCN pipeline can settle.

---
 rtl/misex2_cmd_encoder_if.sv | 26 ++
 rtl/misex2_cmd_encoder.sv | 149 ++++++++++++++
 tb/tb_misex2_cmd_encoder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/misex2_cmd_encoder_if.sv
// misex2_cmd_encoder_if: valid/ready command bus between the encoder and the decoder input side.
//   cmd       - 25-bit control word, bit24=a ... bit0=y
//   cmd_valid - cmd and cmd_idx carry a word
//   cmd_idx   - decoder output index (0..17) asserted by cmd
//   cmd_ready - consumer accepts the word this cycle
// master: the encoder (drives cmd/cmd_valid/cmd_idx). slave: the consumer (drives cmd_ready).
interface misex2_cmd_encoder_if;
    logic [24:0] cmd;
    logic        cmd_valid;
    logic [4:0]  cmd_idx;
    logic        cmd_ready;

    modport master (
        output cmd,
        output cmd_valid,
        output cmd_idx,
        input  cmd_ready
    );

    modport slave (
        input  cmd,
        input  cmd_valid,
        input  cmd_idx,
        output cmd_ready
    );
endinterface

// File: rtl/misex2_cmd_encoder.sv
// misex2_cmd_encoder: collects per-output event requests for the misex2 decoder, arbitrates them
// round-robin and sends the canonical 25-bit input word for each granted output over a valid/ready
// bus, with a DWELL-cycle idle gap after each accepted word.
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   req    - request strobes, one per output index, sampled every cycle
//   cmd_if - command bus (master side): cmd, cmd_valid, cmd_idx out; cmd_ready in
//   drop   - one-cycle pulse: a request hit an index that was already pending
//   busy   - work pending, word on the bus, or dwell gap running
module misex2_cmd_encoder #(
    parameter int unsigned DWELL = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [17:0]                 req,
    misex2_cmd_encoder_if.master        cmd_if,
    output logic                        drop,
    output logic                        busy
);

    localparam bit         ZeroDwell = (DWELL == 0);
    localparam logic [7:0] DwellInit = 8'(DWELL);

    // Canonical input word that asserts decoder output idx; 17 (n1) is the all-zero word.
    function automatic logic [24:0] encode(input logic [4:0] idx);
        logic [24:0] w;
        case (idx)
            5'd0:    w = 25'h0400000;
            5'd1:    w = 25'h0800000;
            5'd2:    w = 25'h000C000;
            5'd3:    w = 25'h0000040;
            5'd4:    w = 25'h0008000;
            5'd5:    w = 25'h1C0C000;
            5'd6:    w = 25'h1C04000;
            5'd7:    w = 25'h1400000;
            5'd8:    w = 25'h1C06000;
            5'd9:    w = 25'h0800040;
            5'd10:   w = 25'h05000A0;
            5'd11:   w = 25'h0800048;
            5'd12:   w = 25'h0004000;
            5'd13:   w = 25'h080004C;
            5'd14:   w = 25'h0000080;
            5'd15:   w = 25'h1808000;
            5'd16:   w = 25'h1000000;
            default: w = 25'h0000000;
        endcase
        return w;
    endfunction

    logic [17:0] pend_q, pend_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [24:0] cmd_q, cmd_d;
    logic        valid_q, valid_d;
    logic [4:0]  idx_q, idx_d;
    logic        drop_q, drop_d;

    logic        xfer;
    logic        grant;
    logic        gnt_found;
    logic [4:0]  gnt_idx;
    logic [5:0]  pos;
    logic [17:0] gnt_vec;

    assign xfer = valid_q & cmd_if.cmd_ready;

    // Round-robin pick: first pending bit scanning ptr, ptr+1, ..., 17, 0, ..., ptr-1.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = 5'd0;
        pos       = 6'd0;
        for (int k = 0; k < 18; k++) begin
            pos = {1'b0, ptr_q} + 6'(k);
            if (pos >= 6'd18) begin
                pos = pos - 6'd18;
            end
            if (!gnt_found && pend_q[pos[4:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = pos[4:0];
            end
        end
    end

    // A grant is allowed when the gap counter is zero or expires on this edge, so exactly DWELL
    // cycles pass with cmd_valid low after each accepted word.
    always_comb begin
        grant = gnt_found && (dwell_q < 8'd2) &&
                (!valid_q || (cmd_if.cmd_ready && ZeroDwell));
    end

    always_comb begin
        pend_d  = pend_q;
        ptr_d   = ptr_q;
        dwell_d = dwell_q;
        cmd_d   = cmd_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        gnt_vec = 18'd0;

        if (xfer && !ZeroDwell) begin
            dwell_d = DwellInit;
        end else if (dwell_q != 8'd0) begin
            dwell_d = dwell_q - 8'd1;
        end

        if (grant) begin
            gnt_vec          = 18'd1 << gnt_idx;
            cmd_d            = encode(gnt_idx);
            idx_d            = gnt_idx;
            valid_d          = 1'b1;
            pend_d[gnt_idx]  = 1'b0;
            ptr_d            = (gnt_idx == 5'd17) ? 5'd0 : gnt_idx + 5'd1;
        end else if (xfer) begin
            valid_d = 1'b0;
        end

        // New requests are ORed in after the grant clear, so a re-request of the index being
        // granted stays pending instead of being lost.
        pend_d = pend_d | req;
        drop_d = |(req & pend_q & ~gnt_vec);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= 18'd0;
            ptr_q   <= 5'd0;
            dwell_q <= 8'd0;
            cmd_q   <= 25'd0;
            valid_q <= 1'b0;
            idx_q   <= 5'd0;
            drop_q  <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            dwell_q <= dwell_d;
            cmd_q   <= cmd_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
        end
    end

    assign cmd_if.cmd       = cmd_q;
    assign cmd_if.cmd_valid = valid_q;
    assign cmd_if.cmd_idx   = idx_q;
    assign drop             = drop_q;
    assign busy             = (pend_q != 18'd0) || valid_q || (dwell_q != 8'd0);

endmodule

// File: tb/tb_misex2_cmd_encoder.sv
// Directed bench for misex2_cmd_encoder: one instance with DWELL=2, one with DWELL=0.
module tb_misex2_cmd_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] req2, req0;
    logic        drop2, drop0, busy2, busy0;

    misex2_cmd_encoder_if if2 ();
    misex2_cmd_encoder_if if0 ();

    misex2_cmd_encoder #(.DWELL(2)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .req    (req2),
        .cmd_if (if2.master),
        .drop   (drop2),
        .busy   (busy2)
    );

    misex2_cmd_encoder #(.DWELL(0)) dut0 (
        .clk    (clk),
        .rst    (rst),
        .req    (req0),
        .cmd_if (if0.master),
        .drop   (drop0),
        .busy   (busy0)
    );

    always #5 clk = ~clk;

    logic [24:0] exp_tab [0:17] = '{
        25'h0400000, 25'h0800000, 25'h000C000, 25'h0000040, 25'h0008000, 25'h1C0C000,
        25'h1C04000, 25'h1400000, 25'h1C06000, 25'h0800040, 25'h05000A0, 25'h0800048,
        25'h0004000, 25'h080004C, 25'h0000080, 25'h1808000, 25'h1000000, 25'h0000000
    };

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; outputs are read 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req2 = '0;
        req0 = '0;
        if2.cmd_ready = 1'b0;
        if0.cmd_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(if2.cmd_valid), 32'd0);
        check("rst_cmd",   32'(if2.cmd),       32'd0);
        check("rst_idx",   32'(if2.cmd_idx),   32'd0);
        check("rst_drop",  32'(drop2),         32'd0);
        check("rst_busy",  32'(busy2),         32'd0);

        // Reset mid-transfer with everything pending.
        req2 = 18'h3FFFF;
        tick();
        tick();
        check("pre_rst_valid", 32'(if2.cmd_valid), 32'd1);
        check("pre_rst_idx",   32'(if2.cmd_idx),   32'd0);
        tick();
        req2 = '0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(if2.cmd_valid), 32'd0);
        check("async_rst_cmd",   32'(if2.cmd),       32'd0);
        check("async_rst_idx",   32'(if2.cmd_idx),   32'd0);
        check("async_rst_drop",  32'(drop2),         32'd0);
        check("async_rst_busy",  32'(busy2),         32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_valid", 32'(if2.cmd_valid), 32'd0);
            check("post_rst_busy",  32'(busy2),         32'd0);
        end

        // DWELL=2 single request for idx 10.
        if2.cmd_ready = 1'b1;
        req2 = 18'd1 << 10;
        tick();
        req2 = '0;
        check("d2_c1_valid", 32'(if2.cmd_valid), 32'd0);
        check("d2_c1_busy",  32'(busy2),         32'd1);
        tick();
        check("d2_c2_valid", 32'(if2.cmd_valid), 32'd1);
        check("d2_c2_cmd",   32'(if2.cmd),       32'h05000A0);
        check("d2_c2_idx",   32'(if2.cmd_idx),   32'd10);
        tick();
        check("d2_c3_valid", 32'(if2.cmd_valid), 32'd0);
        check("d2_c3_busy",  32'(busy2),         32'd1);
        tick();
        check("d2_c4_valid", 32'(if2.cmd_valid), 32'd0);
        tick();
        check("d2_c5_valid", 32'(if2.cmd_valid), 32'd0);
        check("d2_c5_busy",  32'(busy2),         32'd0);
        check("d2_c5_cmd_kept", 32'(if2.cmd),    32'h05000A0);

        // DWELL=0 burst: all 18 words back to back in index order.
        if0.cmd_ready = 1'b1;
        req0 = 18'h3FFFF;
        tick();
        req0 = '0;
        tick();
        for (int k = 0; k < 18; k++) begin
            check("burst_valid", 32'(if0.cmd_valid), 32'd1);
            check("burst_idx",   32'(if0.cmd_idx),   32'(k));
            check("burst_cmd",   32'(if0.cmd),       32'(exp_tab[k]));
            tick();
        end
        check("burst_end_valid", 32'(if0.cmd_valid), 32'd0);
        check("burst_end_cmd",   32'(if0.cmd),       32'd0);

        // Fairness: after idx 4, pointer sits at 5 so 9 beats 2.
        req0 = 18'd1 << 4;
        tick();
        req0 = '0;
        tick();
        check("fair_first_idx", 32'(if0.cmd_idx), 32'd4);
        tick();
        check("fair_gap_valid", 32'(if0.cmd_valid), 32'd0);
        req0 = (18'd1 << 2) | (18'd1 << 9);
        tick();
        req0 = '0;
        tick();
        check("fair_a_valid", 32'(if0.cmd_valid), 32'd1);
        check("fair_a_idx",   32'(if0.cmd_idx),   32'd9);
        tick();
        check("fair_b_valid", 32'(if0.cmd_valid), 32'd1);
        check("fair_b_idx",   32'(if0.cmd_idx),   32'd2);
        tick();
        check("fair_end_valid", 32'(if0.cmd_valid), 32'd0);

        // Re-request of idx 3 in its grant cycle: no drop, sent twice.
        req0 = 18'd1 << 3;
        tick();
        check("same_c1_drop", 32'(drop0), 32'd0);
        tick();
        req0 = '0;
        check("same_c2_valid", 32'(if0.cmd_valid), 32'd1);
        check("same_c2_idx",   32'(if0.cmd_idx),   32'd3);
        check("same_c2_drop",  32'(drop0),         32'd0);
        tick();
        check("same_c3_valid", 32'(if0.cmd_valid), 32'd1);
        check("same_c3_idx",   32'(if0.cmd_idx),   32'd3);
        check("same_c3_drop",  32'(drop0),         32'd0);
        tick();
        check("same_c4_valid", 32'(if0.cmd_valid), 32'd0);
        check("same_c4_busy",  32'(busy0),         32'd0);

        // Backpressure on idx 13 with a duplicate request during the stall.
        if2.cmd_ready = 1'b0;
        req2 = 18'd1 << 13;
        tick();
        req2 = '0;
        tick();
        for (int s = 0; s < 6; s++) begin
            check("stall_valid", 32'(if2.cmd_valid), 32'd1);
            check("stall_cmd",   32'(if2.cmd),       32'h080004C);
            check("stall_idx",   32'(if2.cmd_idx),   32'd13);
            check("stall_drop",  32'(drop2),         (s == 3) ? 32'd1 : 32'd0);
            req2 = (s == 1 || s == 2) ? (18'd1 << 13) : 18'd0;
            tick();
        end
        req2 = '0;
        check("stall_end_valid", 32'(if2.cmd_valid), 32'd1);
        check("stall_end_idx",   32'(if2.cmd_idx),   32'd13);
        if2.cmd_ready = 1'b1;
        tick();
        check("resend_gap1_valid", 32'(if2.cmd_valid), 32'd0);
        tick();
        check("resend_gap2_valid", 32'(if2.cmd_valid), 32'd0);
        tick();
        check("resend_valid", 32'(if2.cmd_valid), 32'd1);
        check("resend_idx",   32'(if2.cmd_idx),   32'd13);
        check("resend_cmd",   32'(if2.cmd),       32'h080004C);
        tick();
        check("resend_after_valid", 32'(if2.cmd_valid), 32'd0);
        tick();
        tick();
        check("resend_idle_busy", 32'(busy2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
